axis_udp_framer: RTL and testbench

- Packs a continuous 32-bit sample stream into the 64-bit word stream consumed by the 10GbE UDP transmit block.
- Every frame is exactly FRAME_WORDS words: one header word followed by FRAME_WORDS-1 data words. This keeps frames aligned with the fixed 8192-byte UDP payloads cut by the downstream stage.
- The source cannot stall. Backpressure mid-frame never shortens a frame; the frame is completed with zero fill and flagged in the next header.

---
 rtl/axis_udp_framer_if.sv | 11 +
 rtl/axis_udp_framer.sv | 144 ++++++++++++++
 tb/tb_axis_udp_framer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_udp_framer_if.sv
// Valid/ready stream bundle used for both the 32-bit sample input and the 64-bit word output.
interface axis_udp_framer_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_udp_framer.sv
// Packs 32-bit samples into fixed-length 64-bit frames (header + data); a word enters the output register the cycle after its second sample.
// The sample side never stalls: backpressure turns the rest of the frame into zero fill and the loss is flagged in the next header.
module axis_udp_framer #(
  parameter int          FRAME_WORDS = 1024,
  parameter logic [15:0] MAGIC       = 16'h5AFE
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              enable,
  axis_udp_framer_if.slave  s_axis,
  axis_udp_framer_if.master m_axis,
  output logic [31:0]       frame_cnt,
  output logic [31:0]       drop_cnt
);
  localparam int               IDX_W    = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HEAD, DATA, FILL} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic             half, half_nxt;
  logic [31:0]      low, low_nxt;
  logic [31:0]      seq, seq_nxt;
  logic             ovf, ovf_nxt;
  logic [63:0]      out_dat;
  logic             out_vld;
  logic             out_last;

  logic             slot_free;
  logic             load;
  logic [63:0]      load_dat;
  logic             load_last;
  logic [1:0]       drop_inc;

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tvalid = out_vld;

  always_comb begin
    slot_free    = !out_vld || m_axis.tready;
    state_nxt    = state;
    word_idx_nxt = word_idx;
    half_nxt     = half;
    low_nxt      = low;
    seq_nxt      = seq;
    ovf_nxt      = ovf;
    load         = 1'b0;
    load_dat     = '0;
    load_last    = 1'b0;
    drop_inc     = '0;

    case (state)
      IDLE: begin
        if (enable) state_nxt = HEAD;
      end
      HEAD: begin
        drop_inc = {1'b0, s_axis.tvalid};
        if (slot_free) begin
          load         = 1'b1;
          load_dat     = {MAGIC, 15'd0, ovf, seq};
          // a drop in the load cycle lands after the clear and flags the next header
          ovf_nxt      = s_axis.tvalid;
          seq_nxt      = seq + 32'd1;
          word_idx_nxt = IDX_W'(1);
          half_nxt     = 1'b0;
          state_nxt    = DATA;
        end else if (s_axis.tvalid) begin
          ovf_nxt = 1'b1;
        end
      end
      DATA: begin
        if (!enable) begin
          // a lone half-packed sample is lost too, so it is counted with this cycle's sample
          drop_inc  = {1'b0, s_axis.tvalid} + {1'b0, half};
          half_nxt  = 1'b0;
          state_nxt = FILL;
        end else if (s_axis.tvalid) begin
          if (!half) begin
            low_nxt  = s_axis.tdata;
            half_nxt = 1'b1;
          end else begin
            half_nxt = 1'b0;
            if (slot_free) begin
              load      = 1'b1;
              load_dat  = {s_axis.tdata, low};
              load_last = (word_idx == LAST_IDX);
            end else begin
              drop_inc  = 2'd2;
              ovf_nxt   = 1'b1;
              state_nxt = FILL;
            end
          end
        end
      end
      FILL: begin
        drop_inc = {1'b0, s_axis.tvalid};
        if (slot_free) begin
          load      = 1'b1;
          load_dat  = '0;
          load_last = (word_idx == LAST_IDX);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load && state != HEAD) begin
      if (load_last) state_nxt = enable ? HEAD : IDLE;
      else           word_idx_nxt = word_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state     <= IDLE;
      word_idx  <= '0;
      half      <= 1'b0;
      low       <= '0;
      seq       <= '0;
      ovf       <= 1'b0;
      out_dat   <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
      half     <= half_nxt;
      low      <= low_nxt;
      seq      <= seq_nxt;
      ovf      <= ovf_nxt;
      drop_cnt <= drop_cnt + 32'(drop_inc);
      if (out_vld && m_axis.tready && out_last) frame_cnt <= frame_cnt + 32'd1;
      if (load) begin
        out_vld  <= 1'b1;
        out_dat  <= load_dat;
        out_last <= load_last;
      end else if (m_axis.tready) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_udp_framer.sv
// Random-data bench: a frame-level reference model queues expected words; a separate monitor pops and compares on every output handshake.
module tb_axis_udp_framer;
  localparam int          FW    = 1024;
  localparam logic [15:0] MAGIC = 16'h5AFE;
  localparam int M_IDLE = 0, M_HEAD = 1, M_DATA = 2, M_FILL = 3;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] frame_cnt, drop_cnt;

  axis_udp_framer_if #(.WIDTH(32)) s_axis ();
  axis_udp_framer_if #(.WIDTH(64)) m_axis ();

  axis_udp_framer #(.FRAME_WORDS(FW), .MAGIC(MAGIC)) dut (
    .aclk(aclk), .arst(arst), .enable(enable),
    .s_axis(s_axis), .m_axis(m_axis),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: words of the current frame put out, samples waiting to pair up
  int          md = M_IDLE;
  int          emitted = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pend[$];
  bit          ovf = 1'b0;
  logic [31:0] seq = '0;
  logic [31:0] m_drops = '0;
  logic [31:0] m_frames = '0;
  bit          reg_full = 1'b0;
  bit          reg_last = 1'b0;
  logic [63:0] hdr_log[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic bound(input string name, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=timeout expected=condition reached", name);
    end
  endtask

  function automatic logic [63:0] hdr(input int i);
    return (i < hdr_log.size()) ? hdr_log[i] : 64'hx;
  endfunction

  task automatic put_word(input logic [63:0] w, input bit is_hdr, input bit en);
    exp_q.push_back(w);
    reg_full = 1'b1;
    emitted++;
    reg_last = !is_hdr && (emitted == FW);
    if (reg_last) md = en ? M_HEAD : M_IDLE;
  endtask

  task automatic model_step(input bit vld, input logic [31:0] dat, input bit rdy, input bit en, input bit rst);
    bit slot;
    logic [63:0] w;
    if (rst) begin
      md = M_IDLE; emitted = 0; ovf = 0; seq = '0; m_drops = '0; m_frames = '0;
      reg_full = 0; reg_last = 0;
      exp_q.delete(); pend.delete();
      return;
    end
    slot = !reg_full || rdy;
    if (reg_full && rdy) begin
      if (reg_last) m_frames++;
      reg_full = 0;
    end
    case (md)
      M_IDLE: if (en) md = M_HEAD;
      M_HEAD: begin
        if (vld) m_drops++;
        if (slot) begin
          emitted = 0;
          put_word({MAGIC, 15'd0, ovf, seq}, 1'b1, en);
          ovf = vld;
          seq++;
          pend.delete();
          md = M_DATA;
        end else if (vld) ovf = 1;
      end
      M_DATA: begin
        if (!en) begin
          m_drops = m_drops + 32'(vld) + 32'(pend.size());
          pend.delete();
          md = M_FILL;
        end else if (vld) begin
          pend.push_back(dat);
          if (pend.size() == 2) begin
            w = {pend[1], pend[0]};
            pend.delete();
            if (slot) put_word(w, 1'b0, en);
            else begin
              m_drops = m_drops + 32'd2;
              ovf = 1;
              md = M_FILL;
            end
          end
        end
      end
      default: begin
        if (vld) m_drops++;
        if (slot) put_word(64'd0, 1'b0, en);
      end
    endcase
  endtask

  task automatic step(input bit vld, input bit rdy, input bit en, input bit rst = 1'b0);
    @(negedge aclk);
    if (cyc % 8 == 0) begin
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("tvalid", 64'(m_axis.tvalid), 64'(reg_full));
      chk("s_tready", 64'(s_axis.tready), 64'd1);
    end
    arst = rst;
    enable = en;
    s_axis.tvalid = vld;
    s_axis.tdata = $urandom;
    m_axis.tready = rdy;
    model_step(vld, s_axis.tdata, rdy, en, rst);
    cyc++;
  endtask

  task automatic do_reset();
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
  endtask

  // monitor: compares every handshaken word and checks that stalled words hold
  initial begin
    logic [63:0] held;
    bit hold;
    int pos;
    hold = 0; pos = 0; held = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (arst) begin
        hold = 0; pos = 0;
        hdr_log.delete();
        continue;
      end
      if (hold) begin
        chk("hold_tvalid", 64'(m_axis.tvalid), 64'd1);
        chk("hold_tdata", m_axis.tdata, held);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word got=%h expected=none", m_axis.tdata);
        end else begin
          chk("word", m_axis.tdata, exp_q.pop_front());
        end
        if (pos == 0) hdr_log.push_back(m_axis.tdata);
        pos = (pos + 1) % FW;
      end
      hold = m_axis.tvalid && !m_axis.tready;
      held = m_axis.tdata;
    end
  end

  initial begin
    s_axis.tvalid = 0; s_axis.tdata = '0; m_axis.tready = 1;
    do_reset();
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", m_axis.tdata, 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_s_tready", 64'(s_axis.tready), 64'd1);

    // full-rate input, no backpressure
    for (int i = 0; i < 6000 && m_frames < 2; i++) step(1, 1, 1);
    bound("t1_frames", m_frames >= 2);
    chk("t1_hdr0", hdr(0), 64'h5AFE_0000_0000_0000);
    chk("t1_hdr1_seq", 64'(hdr(1)[31:0]), 64'd1);
    chk("t1_hdr1_flag", 64'(hdr(1)[32]), 64'd1);

    // half-rate input phased so header cycles never coincide with a sample
    do_reset();
    step(1, 1, 1);
    for (int i = 1; i < 9000 && m_frames < 2; i++) step(i % 2 == 0, 1, 1);
    bound("t2_frames", m_frames >= 2);
    chk("t2_drops", 64'(drop_cnt), 64'd0);
    chk("t2_hdr1_flag", 64'(hdr(1)[32]), 64'd0);
    chk("t2_hdr1_seq", 64'(hdr(1)[31:0]), 64'd1);

    // backpressure mid-frame forces zero fill
    do_reset();
    for (int i = 0; i < 3000 && !(md == M_DATA && emitted == 500); i++) step(1, 1, 1);
    bound("t3_reach500", md == M_DATA && emitted == 500);
    for (int i = 0; i < 6; i++) step(1, 0, 1);
    chk("t3_in_fill", 64'(md), 64'(M_FILL));
    for (int i = 0; i < 3000 && hdr_log.size() < 2; i++) step(1, 1, 1);
    bound("t3_next_hdr", hdr_log.size() >= 2);
    chk("t3_hdr1_flag", 64'(hdr(1)[32]), 64'd1);
    checks++;
    if (drop_cnt < 2) begin
      failures++;
      $display("FAIL t3_drops got=%0d expected>=2", drop_cnt);
    end

    // enable removed mid-frame, then re-enabled
    do_reset();
    for (int i = 0; i < 100 && md != M_DATA; i++) step(0, 1, 1);
    for (int i = 0; i < 3000 && emitted < 300; i++) step(1, 1, 1);
    bound("t4_reach300", emitted >= 300);
    for (int i = 0; i < 3000 && !(md == M_IDLE && !reg_full); i++) step(1, 1, 0);
    bound("t4_idle", md == M_IDLE);
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t4_hdr_count", 64'(hdr_log.size()), 64'd1);
    for (int i = 0; i < 100 && hdr_log.size() < 2; i++) step(0, 1, 1);
    chk("t4_hdr1_seq", 64'(hdr(1)[31:0]), 64'd1);
    chk("t4_hdr1_flag", 64'(hdr(1)[32]), 64'd0);

    // reset mid-frame
    do_reset();
    for (int i = 0; i < 3000 && emitted < 700; i++) step(1, 1, 1);
    bound("t5_reach700", emitted >= 700);
    step(1, 1, 1, 1);
    step(1, 1, 1);
    chk("t5_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 100 && hdr_log.size() < 1; i++) step(1, 1, 1);
    chk("t5_hdr_seq", 64'(hdr(0)[31:0]), 64'd0);

    // toggling ready, one sample every fourth cycle
    do_reset();
    step(0, 1, 1);
    for (int i = 1; i < 12000 && m_frames < 1; i++) step(i % 4 == 2, i % 2 == 1, 1);
    bound("t6_frames", m_frames >= 1);
    chk("t6_drops", 64'(drop_cnt), 64'd0);

    // random traffic, ready and enable
    do_reset();
    begin
      bit en;
      en = 1;
      for (int i = 0; i < 5000; i++) begin
        if ($urandom_range(0, 499) == 0) en = !en;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, en);
      end
    end
    for (int i = 0; i < 3000 && !(md == M_IDLE && !reg_full); i++) step(0, 1, 0);
    bound("drain_idle", md == M_IDLE && !reg_full);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    #2;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("final_frame_cnt", 64'(frame_cnt), 64'(m_frames));
    chk("final_drop_cnt", 64'(drop_cnt), 64'(m_drops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
